cordic_iter_ctrl: RTL
=====================

Name: cordic_iter_ctrl

Overview:
- Iteration controller FSM for the hyperbolic CORDIC core of the natural-logarithm unit.
- Drives the enable and clear inputs of the 5-bit iteration counter, and consumes its count to produce the per-iteration shift index.
- Inserts the mandatory hyperbolic repeat iterations.
- Sequences initial-operand load, the iteration loop, result capture and the start/done handshake with the top-level control.

Parameters:
- P, 5: iteration counter width; must match the counter instance.
- ITERS, 24: last shift index executed; 1 ≤ ITERS ≤ 2^P − 1.
- REP0, 4: first shift index executed twice.
- REP1, 13: second shift index executed twice.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- BEG_FSM  in  1  start request; sampled in IDLE only.
- ACK_FSM  in  1  result consumed; sampled in DONE only.
- ITER_CNT  in  P  current value of the external iteration counter (synchronous clear, +1 on enable).
- CNT_EN  out  1  counter increment enable.
- CNT_RST  out  1  counter synchronous clear.
- LOAD_INIT  out  1  datapath loads initial x/y/z.
- ITER_EN  out  1  datapath performs one CORDIC micro-rotation this cycle.
- SHIFT_AMT  out  P  shift index for this micro-rotation.
- REPEAT  out  1  current micro-rotation is the repeated copy.
- LOAD_RESULT  out  1  capture z into the result register.
- READY  out  1  idle, start accepted.
- DONE  out  1  result valid; held until ACK_FSM.

Behaviour:
- Reset is asynchronous and active-high: CLK and RST, one clock.
- Asserting RST forces state = IDLE and rep_done = 0 immediately, independent of CLK.
- All outputs are decoded from registered state and ITER_CNT (Moore plus the ITER_CNT decode). No output depends on BEG_FSM or ACK_FSM combinationally.
- Output values in reset / IDLE: READY = 1, CNT_RST = 1, all other outputs 0, SHIFT_AMT = 0.
- Because CNT_RST = 1 in IDLE, the synchronous counter clears on the first clock edge after RST deasserts.
- IDLE:
  - READY = 1, CNT_RST = 1.
  - BEG_FSM = 1 → INIT.
- INIT, one cycle:
  - LOAD_INIT = 1, CNT_RST = 1.
  - → ITER.
  - ITER_CNT is therefore 0 on the first ITER cycle.
- ITER:
  - ITER_EN = 1; SHIFT_AMT = ITER_CNT + 1, computed modulo 2^P.
  - Repeat case: if SHIFT_AMT ∈ {REP0, REP1} and rep_done = 0, then REPEAT = 0, CNT_EN = 0, rep_done ← 1. The same index is presented again next cycle.
  - Repeat copy: if rep_done = 1, then REPEAT = 1, CNT_EN = 1, rep_done ← 0.
  - All other indices: CNT_EN = 1, rep_done stays 0.
  - Exit: when SHIFT_AMT = ITERS and no repeat is pending for that index → RESULT.
- RESULT, one cycle:
  - LOAD_RESULT = 1, CNT_RST = 1.
  - → DONE.
- DONE:
  - DONE = 1.
  - ACK_FSM = 1 → IDLE on the next edge. Otherwise hold.
- Latency:
  - ITER cycle count = ITERS + (number of REPx ≤ ITERS); 26 for the defaults.
  - BEG_FSM sampled at edge 0 → LOAD_INIT in cycle 1 → ITER in cycles 2..27 → LOAD_RESULT in cycle 28 → DONE from cycle 29.
- Boundaries:
  - BEG_FSM outside IDLE is ignored, not queued.
  - ACK_FSM outside DONE is ignored.
  - BEG_FSM and ACK_FSM both high in DONE → IDLE only; a new start needs BEG_FSM in IDLE.
  - If ITERS = REPx, the repeat executes before exit.
  - If ITERS < REP0, no repeats occur; ITERS = 1 gives a single ITER cycle.
  - RST mid-ITER aborts: IDLE immediately, rep_done cleared, counter cleared on the next edge.
  - ITER_CNT + 1 wrap is unreachable given the ITERS constraint.
- Elaboration check: fatal if ITERS > 2^P − 1 or REP0 ≥ REP1.

Decomposition:
- Shared package `ln_cordic_pkg`:
  - state encoding: IDLE, INIT, ITER, RESULT, DONE, 3 bits;
  - default ITERS, REP0, REP1;
  - counter width P.
- No sub-module. The repeat detector is two comparators inline.
- The iteration counter stays a separate sibling instance wired CNT_EN → EN, CNT_RST → RST, Y → ITER_CNT.

Test Plan:
- Reset: assert RST asynchronously mid-cycle → READY = 1, CNT_RST = 1 and DONE = 0 without a clock edge; counter reads 0 after the first edge.
- Nominal run with defaults and a counter model: pulse BEG_FSM → exactly 26 ITER_EN cycles with SHIFT_AMT sequence 1,2,3,4,4,5,…,13,13,…,24, REPEAT high only on the second 4 and the second 13. LOAD_RESULT in cycle 28, DONE from cycle 29.
- Handshake: hold ACK_FSM low for 10 cycles → DONE stays 1. Assert ACK_FSM together with BEG_FSM → IDLE, no restart. A following BEG_FSM starts a new run with SHIFT_AMT = 1.
- Ignored inputs: BEG_FSM pulsed during ITER, and ACK_FSM pulsed during ITER → no change to the sequence or to the 26-cycle count.
- Abort: assert RST at the cycle with SHIFT_AMT = 13, REPEAT = 0 → IDLE. A next run shows full repeats at 4 and 13, so no stale rep_done.
- Edge parameters:
  - ITERS = 4 → shifts 1,2,3,4,4, then RESULT.
  - ITERS = 3 → shifts 1,2,3, no REPEAT.
  - ITERS = 31, P = 5 → last SHIFT_AMT = 31, ITER_CNT never wraps.

Source files
------------

// File: rtl/ln_cordic_pkg.sv
// Shared types and defaults for the hyperbolic CORDIC natural-log unit.
// State encoding, iteration counter width and the default repeat schedule.
package ln_cordic_pkg;

  localparam int CNT_W     = 5;
  localparam int DEF_ITERS = 24;
  localparam int DEF_REP0  = 4;
  localparam int DEF_REP1  = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ITER   = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Iteration controller for the hyperbolic CORDIC core: load, micro-rotation loop with
// repeated indices, result capture and start/done handshake. Outputs are Moore plus ITER_CNT decode.
module cordic_iter_ctrl
  import ln_cordic_pkg::*;
#(
  parameter int P     = CNT_W,
  parameter int ITERS = DEF_ITERS,
  parameter int REP0  = DEF_REP0,
  parameter int REP1  = DEF_REP1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG_FSM,
  input  logic         ACK_FSM,
  input  logic [P-1:0] ITER_CNT,
  output logic         CNT_EN,
  output logic         CNT_RST,
  output logic         LOAD_INIT,
  output logic         ITER_EN,
  output logic [P-1:0] SHIFT_AMT,
  output logic         REPEAT,
  output logic         LOAD_RESULT,
  output logic         READY,
  output logic         DONE
);

  generate
    if (ITERS < 1 || ITERS > (2**P) - 1 || REP0 >= REP1) begin : g_bad_cfg
      $fatal(1, "cordic_iter_ctrl: illegal ITERS/REP0/REP1 for counter width P");
    end
  endgenerate

  localparam logic [P-1:0] ITERS_I = P'(ITERS);
  localparam logic [P-1:0] REP0_I  = P'(REP0);
  localparam logic [P-1:0] REP1_I  = P'(REP1);

  state_t       state;
  state_t       state_nxt;
  logic         rep_done;
  logic         rep_done_nxt;
  logic [P-1:0] shift_idx;
  logic         rep_idx;
  logic         rep_hold;
  logic         last_idx;

  // The counter is cleared on entry to ITER, so the shift index runs one ahead of it.
  assign shift_idx = ITER_CNT + P'(1);
  assign rep_idx   = (shift_idx == REP0_I) || (shift_idx == REP1_I);
  assign rep_hold  = rep_idx && !rep_done;
  assign last_idx  = (shift_idx == ITERS_I) && !rep_hold;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      rep_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      rep_done <= rep_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rep_done_nxt = rep_done;
    case (state)
      S_IDLE: begin
        if (BEG_FSM) state_nxt = S_INIT;
      end
      S_INIT: begin
        rep_done_nxt = 1'b0;
        state_nxt    = S_ITER;
      end
      S_ITER: begin
        // First copy of a repeat index holds the counter; the second copy releases it.
        rep_done_nxt = rep_hold;
        if (last_idx) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ACK_FSM) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt    = S_IDLE;
        rep_done_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    CNT_EN      = 1'b0;
    CNT_RST     = 1'b0;
    LOAD_INIT   = 1'b0;
    ITER_EN     = 1'b0;
    SHIFT_AMT   = '0;
    REPEAT      = 1'b0;
    LOAD_RESULT = 1'b0;
    READY       = 1'b0;
    DONE        = 1'b0;
    case (state)
      S_IDLE: begin
        READY   = 1'b1;
        CNT_RST = 1'b1;
      end
      S_INIT: begin
        LOAD_INIT = 1'b1;
        CNT_RST   = 1'b1;
      end
      S_ITER: begin
        ITER_EN   = 1'b1;
        SHIFT_AMT = shift_idx;
        REPEAT    = rep_done;
        CNT_EN    = !rep_hold;
      end
      S_RESULT: begin
        LOAD_RESULT = 1'b1;
        CNT_RST     = 1'b1;
      end
      S_DONE: begin
        DONE = 1'b1;
      end
      default: begin
        READY   = 1'b1;
        CNT_RST = 1'b1;
      end
    endcase
  end

endmodule
